// File: rtl/act_packer_if.sv
// Handshake bundle for act_packer: the valid-only sample stream in, the
// ready/valid packed-word stream out.
interface act_packer_if;
    logic        data_valid;
    logic [31:0] data;
    logic [4:0]  shift;
    logic        flush;
    logic        word_valid;
    logic [31:0] word;
    logic [3:0]  mask;
    logic        word_ready;

    modport master (
        output data_valid, data, shift, flush, word_ready,
        input  word_valid, word, mask
    );

    modport slave (
        input  data_valid, data, shift, flush, word_ready,
        output word_valid, word, mask
    );
endinterface

// File: rtl/act_packer.sv
// Requantizes signed 32-bit activations to int8 by arithmetic right shift and
// saturation, packs four bytes little-endian per word, and queues the words in a FIFO.
module act_packer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    act_packer_if.slave                bus_io,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic              s1_valid_q, s1_flush_q;
    logic [7:0]        s1_byte_q, s1_byte_d;
    logic signed [31:0] shifted;

    always_comb begin
        shifted = $signed(bus_io.data) >>> bus_io.shift;
        if (shifted > 32'sd127) begin
            s1_byte_d = 8'h7F;
        end else if (shifted < -32'sd128) begin
            s1_byte_d = 8'h80;
        end else begin
            s1_byte_d = shifted[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_byte_q  <= 8'h00;
        end else begin
            s1_valid_q <= bus_io.data_valid;
            s1_flush_q <= bus_io.flush;
            s1_byte_q  <= s1_byte_d;
        end
    end

    logic [1:0]  lane_q, lane_d;
    logic [23:0] acc_q, acc_d;
    logic        push;
    logic [35:0] push_entry;

    // Sample is applied first; a same-cycle flush then sees the updated lane count.
    always_comb begin
        lane_d     = lane_q;
        acc_d      = acc_q;
        push       = 1'b0;
        push_entry = '0;
        if (s1_valid_q) begin
            unique case (lane_q)
                2'd0: begin acc_d[7:0]   = s1_byte_q; lane_d = 2'd1; end
                2'd1: begin acc_d[15:8]  = s1_byte_q; lane_d = 2'd2; end
                2'd2: begin acc_d[23:16] = s1_byte_q; lane_d = 2'd3; end
                default: begin
                    push       = 1'b1;
                    push_entry = {4'b1111, s1_byte_q, acc_q};
                    lane_d     = 2'd0;
                    acc_d      = '0;
                end
            endcase
        end
        if (s1_flush_q && (lane_d != 2'd0)) begin
            push = 1'b1;
            unique case (lane_d)
                2'd1:    push_entry = {4'b0001, 24'h0, acc_d[7:0]};
                2'd2:    push_entry = {4'b0011, 16'h0, acc_d[15:0]};
                default: push_entry = {4'b0111, 8'h0, acc_d};
            endcase
            lane_d = 2'd0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= 2'd0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q;
    logic          empty, full, pop, wr_en;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LW'(DEPTH));
        pop     = !empty && bus_io.word_ready;
        wr_en   = push && (!full || pop);
        level_d = level_q + LW'(wr_en) - LW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= push_entry;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            level_q <= level_d;
        end
    end

    always_comb begin
        bus_io.word_valid = !empty;
        bus_io.word       = empty ? 32'h0 : mem_q[rptr_q][31:0];
        bus_io.mask       = empty ? 4'h0 : mem_q[rptr_q][35:32];
        level_o           = level_q;
        overflow_o        = overflow_q;
    end
endmodule
